// File: rtl/warp_scalar_reg_file.sv
// Multi-warp scalar register file with a per-warp divergence stack that saves
// and restores the execution-mask register (r[NUM_REGS-1]).
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package warp_scalar_reg_file_pkg;
    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;

    typedef enum logic [2:0] {
        ALU_OUT          = 3'd0,
        LSU_OUT          = 3'd1,
        IMMEDIATE        = 3'd2,
        PC_PLUS_1        = 3'd3,
        VECTOR_TO_SCALAR = 3'd4
    } reg_input_mux_t;

    typedef logic [11:0] instruction_memory_address_t;
endpackage

module warp_scalar_reg_file
    import warp_scalar_reg_file_pkg::*;
#(
    parameter int DATA_WIDTH       = `DATA_WIDTH,
    parameter int NUM_WARPS        = 4,
    parameter int NUM_REGS         = 32,
    parameter int MASK_STACK_DEPTH = 8,
    localparam int RW = $clog2(NUM_REGS),
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int DW = $clog2(MASK_STACK_DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  warp_state_t                     warp_state,
    input  logic [WW-1:0]                   read_warp_id,
    input  logic [RW-1:0]                   decoded_rs1_address,
    input  logic [RW-1:0]                   decoded_rs2_address,
    output logic [DATA_WIDTH-1:0]           rs1,
    output logic [DATA_WIDTH-1:0]           rs2,
    input  logic [WW-1:0]                   write_warp_id,
    input  logic                            decoded_reg_write_enable,
    input  logic [RW-1:0]                   decoded_rd_address,
    input  reg_input_mux_t                  decoded_reg_input_mux,
    input  logic [DATA_WIDTH-1:0]           decoded_immediate,
    input  logic [DATA_WIDTH-1:0]           alu_out,
    input  logic [DATA_WIDTH-1:0]           lsu_out,
    input  logic [DATA_WIDTH-1:0]           vector_to_scalar_data,
    input  instruction_memory_address_t     pc,
    input  logic                            mask_push,
    input  logic                            mask_pop,
    input  logic [DATA_WIDTH-1:0]           push_mask,
    output logic [NUM_WARPS*DATA_WIDTH-1:0] warp_execution_masks,
    output logic [DW-1:0]                   mask_stack_depth,
    output logic [NUM_WARPS-1:0]            stack_overflow,
    output logic [NUM_WARPS-1:0]            stack_underflow,
    input  logic [WW-1:0]                   debug_warp_id,
    input  logic [RW-1:0]                   debug_reg_addr,
    output logic [DATA_WIDTH-1:0]           debug_reg_data
);
    localparam int MASK_REG = NUM_REGS - 1;
    localparam int PCW      = $bits(instruction_memory_address_t);

    logic [DATA_WIDTH-1:0] regs_q  [NUM_WARPS][NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d  [NUM_WARPS][NUM_REGS];
    logic [DATA_WIDTH-1:0] stack_q [NUM_WARPS][MASK_STACK_DEPTH];
    logic [DATA_WIDTH-1:0] stack_d [NUM_WARPS][MASK_STACK_DEPTH];
    logic [DW-1:0]         depth_q [NUM_WARPS];
    logic [DW-1:0]         depth_d [NUM_WARPS];
    logic [NUM_WARPS-1:0]  ovf_q, ovf_d;
    logic [NUM_WARPS-1:0]  unf_q, unf_d;

    logic                  upd_s;
    logic                  wr_src_ok_s;
    logic                  wr_hit_s;
    logic                  sel_s;
    logic [DATA_WIDTH-1:0] wr_data_s;
    logic [PCW:0]          pc_inc_s;
    logic [DATA_WIDTH-1:0] rs1_s, rs2_s;

    // Next-state: register writes first, then mask ops so they win on MASK_REG.
    always_comb begin
        regs_d      = regs_q;
        stack_d     = stack_q;
        depth_d     = depth_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        wr_data_s   = '0;
        wr_src_ok_s = 1'b0;
        sel_s       = 1'b0;
        upd_s       = enable && (warp_state == WARP_UPDATE);
        pc_inc_s    = {1'b0, pc} + {{PCW{1'b0}}, 1'b1};

        case (decoded_reg_input_mux)
            ALU_OUT:          begin wr_data_s = alu_out;               wr_src_ok_s = 1'b1; end
            LSU_OUT:          begin wr_data_s = lsu_out;               wr_src_ok_s = 1'b1; end
            IMMEDIATE:        begin wr_data_s = decoded_immediate;     wr_src_ok_s = 1'b1; end
            PC_PLUS_1:        begin wr_data_s = DATA_WIDTH'(pc_inc_s); wr_src_ok_s = 1'b1; end
            VECTOR_TO_SCALAR: begin wr_data_s = vector_to_scalar_data; wr_src_ok_s = 1'b1; end
            default:          begin wr_data_s = '0;                    wr_src_ok_s = 1'b0; end
        endcase

        wr_hit_s = upd_s && decoded_reg_write_enable &&
                   (decoded_rd_address != '0) && wr_src_ok_s;

        for (int w = 0; w < NUM_WARPS; w++) begin
            sel_s = upd_s && (WW'(w) == write_warp_id);
            regs_d[w][decoded_rd_address] = (sel_s && wr_hit_s) ? wr_data_s
                                                                 : regs_q[w][decoded_rd_address];
            case ({sel_s, mask_push, mask_pop})
                3'b111: begin
                    regs_d[w][MASK_REG] = push_mask;
                end
                3'b110: begin
                    if (depth_q[w] < DW'(MASK_STACK_DEPTH)) begin
                        for (int s = 0; s < MASK_STACK_DEPTH; s++) begin
                            stack_d[w][s] = (DW'(s) == depth_q[w]) ? regs_q[w][MASK_REG]
                                                                   : stack_q[w][s];
                        end
                        regs_d[w][MASK_REG] = push_mask;
                        depth_d[w]          = depth_q[w] + DW'(1);
                    end else begin
                        regs_d[w][MASK_REG] = regs_q[w][MASK_REG];
                        ovf_d[w]            = 1'b1;
                    end
                end
                3'b101: begin
                    if (depth_q[w] != '0) begin
                        for (int s = 0; s < MASK_STACK_DEPTH; s++) begin
                            regs_d[w][MASK_REG] = (DW'(s + 1) == depth_q[w]) ? stack_q[w][s]
                                                                             : regs_d[w][MASK_REG];
                        end
                        depth_d[w] = depth_q[w] - DW'(1);
                    end else begin
                        regs_d[w][MASK_REG] = regs_q[w][MASK_REG];
                        unf_d[w]            = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous reset to the architectural reset image.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    regs_q[w][r] <= ((r == 1) || (r == MASK_REG)) ? '1 : '0;
                end
                for (int s = 0; s < MASK_STACK_DEPTH; s++) begin
                    stack_q[w][s] <= '0;
                end
                depth_q[w] <= '0;
            end
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            regs_q  <= regs_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Combinational read ports; OR-select avoids indexing past NUM_WARPS.
    always_comb begin
        rs1_s                = '0;
        rs2_s                = '0;
        debug_reg_data       = '0;
        mask_stack_depth     = '0;
        warp_execution_masks = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            rs1_s = rs1_s | ((WW'(w) == read_warp_id) ? regs_q[w][decoded_rs1_address] : '0);
            rs2_s = rs2_s | ((WW'(w) == read_warp_id) ? regs_q[w][decoded_rs2_address] : '0);
            debug_reg_data   = debug_reg_data |
                               ((WW'(w) == debug_warp_id) ? regs_q[w][debug_reg_addr] : '0);
            mask_stack_depth = mask_stack_depth |
                               ((WW'(w) == debug_warp_id) ? depth_q[w] : '0);
            warp_execution_masks[w*DATA_WIDTH +: DATA_WIDTH] = regs_q[w][MASK_REG];
        end
        rs1 = reset ? '0 : rs1_s;
        rs2 = reset ? '0 : rs2_s;
    end

    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_warp_scalar_reg_file.sv
// Directed self-checking bench for warp_scalar_reg_file (4 warps, 32 regs, stack depth 2).
module tb_warp_scalar_reg_file;
    import warp_scalar_reg_file_pkg::*;

    localparam int DWID = 32;
    localparam int NW   = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  enable;
    warp_state_t           warp_state;
    logic [1:0]            read_warp_id;
    logic [4:0]            rs1_addr, rs2_addr;
    logic [DWID-1:0]       rs1, rs2;
    logic [1:0]            write_warp_id;
    logic                  we;
    logic [4:0]            rd;
    reg_input_mux_t        mux;
    logic [DWID-1:0]       imm, alu, lsu, v2s;
    instruction_memory_address_t pc;
    logic                  push, pop;
    logic [DWID-1:0]       push_mask;
    logic [NW*DWID-1:0]    masks;
    logic [1:0]            depth;
    logic [NW-1:0]         ovf, unf;
    logic [1:0]            dbg_warp;
    logic [4:0]            dbg_addr;
    logic [DWID-1:0]       dbg_data;

    int checks = 0;
    int errors = 0;

    warp_scalar_reg_file #(
        .DATA_WIDTH(DWID), .NUM_WARPS(NW), .NUM_REGS(32), .MASK_STACK_DEPTH(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .warp_state(warp_state),
        .read_warp_id(read_warp_id), .decoded_rs1_address(rs1_addr),
        .decoded_rs2_address(rs2_addr), .rs1(rs1), .rs2(rs2),
        .write_warp_id(write_warp_id), .decoded_reg_write_enable(we),
        .decoded_rd_address(rd), .decoded_reg_input_mux(mux),
        .decoded_immediate(imm), .alu_out(alu), .lsu_out(lsu),
        .vector_to_scalar_data(v2s), .pc(pc), .mask_push(push), .mask_pop(pop),
        .push_mask(push_mask), .warp_execution_masks(masks),
        .mask_stack_depth(depth), .stack_overflow(ovf), .stack_underflow(unf),
        .debug_warp_id(dbg_warp), .debug_reg_addr(dbg_addr), .debug_reg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; push = 1'b0; pop = 1'b0;
        mux = ALU_OUT; enable = 1'b1; warp_state = WARP_UPDATE;
    endtask

    task automatic wr(input logic [1:0] w, input logic [4:0] r, input reg_input_mux_t m,
                      input logic [31:0] val);
        write_warp_id = w; rd = r; mux = m; we = 1'b1;
        alu = val; lsu = val; imm = val; v2s = val;
        step();
        idle();
    endtask

    task automatic mop(input logic [1:0] w, input logic ps, input logic pp, input logic [31:0] m);
        write_warp_id = w; push = ps; pop = pp; push_mask = m;
        step();
        idle();
    endtask

    function automatic logic [31:0] mask_of(input int w);
        return masks[w*DWID +: DWID];
    endfunction

    initial begin
        reset = 1'b1; idle();
        read_warp_id = 2'd2; rs1_addr = 5'd1; rs2_addr = 5'd5;
        write_warp_id = 2'd0; rd = 5'd0; imm = '0; alu = '0; lsu = '0; v2s = '0;
        pc = '0; push_mask = '0; dbg_warp = 2'd2; dbg_addr = 5'd0;
        step();
        check("rs1_during_reset", rs1, 32'h0000_0000);
        reset = 1'b0;
        #1;
        check("rst_r1", rs1, 32'hFFFF_FFFF);
        check("rst_r5", rs2, 32'h0000_0000);
        check("rst_mask", mask_of(2), 32'hFFFF_FFFF);
        check("rst_depth", {30'd0, depth}, 32'd0);
        check("rst_ovf", {28'd0, ovf}, 32'd0);
        check("rst_unf", {28'd0, unf}, 32'd0);

        // write sources and r0
        wr(2'd1, 5'd7, ALU_OUT, 32'h0000_1234);
        read_warp_id = 2'd1; rs1_addr = 5'd7; #1;
        check("w1_r7_alu", rs1, 32'h0000_1234);
        read_warp_id = 2'd0; #1;
        check("w0_r7_zero", rs1, 32'h0000_0000);
        wr(2'd1, 5'd0, ALU_OUT, 32'h0000_DEAD);
        read_warp_id = 2'd1; rs1_addr = 5'd0; #1;
        check("r0_zero", rs1, 32'h0000_0000);
        pc = 12'd9;
        wr(2'd1, 5'd8, PC_PLUS_1, 32'h0);
        rs2_addr = 5'd8; #1;
        check("pc_plus_1", rs2, 32'd10);
        warp_state = WARP_EXECUTE; write_warp_id = 2'd1; rd = 5'd8; we = 1'b1; alu = 32'h9999;
        step(); idle(); #1;
        check("no_upd_state", rs2, 32'd10);
        enable = 1'b0; write_warp_id = 2'd1; rd = 5'd8; we = 1'b1; alu = 32'h9999;
        step(); idle(); #1;
        check("no_upd_enable", rs2, 32'd10);
        wr(2'd1, 5'd8, reg_input_mux_t'(3'd7), 32'h7777);
        check("bad_mux", rs2, 32'd10);
        wr(2'd1, 5'd9, LSU_OUT, 32'hCAFE_0001);
        dbg_warp = 2'd1; dbg_addr = 5'd9; #1;
        check("lsu_dbg", dbg_data, 32'hCAFE_0001);
        wr(2'd1, 5'd10, VECTOR_TO_SCALAR, 32'h0BAD_F00D);
        dbg_addr = 5'd10; #1;
        check("v2s_dbg", dbg_data, 32'h0BAD_F00D);
        // read of a register being written in the same cycle returns the old value
        write_warp_id = 2'd1; rd = 5'd7; mux = IMMEDIATE; imm = 32'h5555; we = 1'b1;
        rs1_addr = 5'd7; #1;
        check("no_bypass_old", rs1, 32'h0000_1234);
        step(); idle(); #1;
        check("no_bypass_new", rs1, 32'h0000_5555);

        // push/pop on warp 0
        dbg_warp = 2'd0;
        mop(2'd0, 1'b1, 1'b0, 32'h0F);
        mop(2'd0, 1'b1, 1'b0, 32'h03);
        check("push2_mask", mask_of(0), 32'h03);
        check("push2_depth", {30'd0, depth}, 32'd2);
        mop(2'd0, 1'b0, 1'b1, 32'h0);
        check("pop1_mask", mask_of(0), 32'h0F);
        mop(2'd0, 1'b0, 1'b1, 32'h0);
        check("pop2_mask", mask_of(0), 32'hFFFF_FFFF);
        check("pop2_depth", {30'd0, depth}, 32'd0);
        check("w1_mask_untouched", mask_of(1), 32'hFFFF_FFFF);
        check("flags_clean", {24'd0, ovf, unf}, 32'd0);

        // overflow / underflow with depth 2
        mop(2'd0, 1'b1, 1'b0, 32'hA1);
        mop(2'd0, 1'b1, 1'b0, 32'hA2);
        mop(2'd0, 1'b1, 1'b0, 32'hA3);
        check("ovf_depth", {30'd0, depth}, 32'd2);
        check("ovf_mask", mask_of(0), 32'hA2);
        check("ovf_flag", {28'd0, ovf}, 32'h1);
        mop(2'd0, 1'b0, 1'b1, 32'h0);
        check("ovf_pop_mask", mask_of(0), 32'hA1);
        mop(2'd0, 1'b0, 1'b1, 32'h0);
        mop(2'd0, 1'b0, 1'b1, 32'h0);
        check("unf_mask", mask_of(0), 32'hFFFF_FFFF);
        check("unf_flag", {28'd0, unf}, 32'h1);
        check("ovf_sticky", {28'd0, ovf}, 32'h1);

        // simultaneous push+pop on warp 1
        dbg_warp = 2'd1;
        mop(2'd1, 1'b1, 1'b0, 32'h0F);
        mop(2'd1, 1'b1, 1'b1, 32'hAA);
        check("pp_mask", mask_of(1), 32'hAA);
        check("pp_depth", {30'd0, depth}, 32'd1);
        check("pp_no_flags", {30'd0, ovf[1], unf[1]}, 32'd0);
        write_warp_id = 2'd1; rd = 5'd31; mux = ALU_OUT; alu = 32'h55; we = 1'b1;
        push = 1'b1; push_mask = 32'h11;
        step(); idle(); #1;
        check("mask_op_wins", mask_of(1), 32'h11);
        check("mask_op_depth", {30'd0, depth}, 32'd2);
        // full stack: overflowing push must also block the MASK_REG write
        write_warp_id = 2'd1; rd = 5'd31; mux = ALU_OUT; alu = 32'h66; we = 1'b1;
        push = 1'b1; push_mask = 32'h22;
        step(); idle(); #1;
        check("ovf_blocks_write", mask_of(1), 32'h11);

        // reset mid-operation on warp 2
        dbg_warp = 2'd2; read_warp_id = 2'd2; rs1_addr = 5'd4;
        write_warp_id = 2'd2; rd = 5'd4; mux = ALU_OUT; alu = 32'h44; we = 1'b1;
        push = 1'b1; push_mask = 32'h22; reset = 1'b1;
        step(); idle(); reset = 1'b0; #1;
        check("rst_mid_depth", {30'd0, depth}, 32'd0);
        check("rst_mid_mask", mask_of(2), 32'hFFFF_FFFF);
        check("rst_mid_r4", rs1, 32'h0);
        check("rst_mid_w1_mask", mask_of(1), 32'hFFFF_FFFF);
        check("rst_mid_flags", {24'd0, ovf, unf}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/warp_scalar_reg_file.md
# warp_scalar_reg_file

Multi-warp scalar register file: one instance holds the scalar registers of `NUM_WARPS` warps, each with `NUM_REGS` registers of `DATA_WIDTH` bits. It also holds a per-warp divergence stack that saves and restores the execution-mask register. It sits between the decoder/issue stage, which supplies the read warp and rs addresses, and the writeback stage, which supplies the write warp and rd/mux/data. It replaces per-warp register-file instances in the compute core.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): register width.
- `NUM_WARPS`, default 4: number of warp register sets; must be ≥ 1.
- `NUM_REGS`, default 32: registers per warp; power of two, ≥ 4. Address width `RW = $clog2(NUM_REGS)`.
- `MASK_STACK_DEPTH`, default 8: divergence-stack entries per warp; must be ≥ 1.

Ports (`WW = max(1,$clog2(NUM_WARPS))`, `DW = $clog2(MASK_STACK_DEPTH+1)`):
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: global update enable.
- `warp_state` in `warp_state_t`: updates happen only when this equals `WARP_UPDATE`.
- `read_warp_id` in WW: warp whose registers drive `rs1`/`rs2`.
- `decoded_rs1_address`, `decoded_rs2_address` in RW: source register indices.
- `rs1`, `rs2` out DATA_WIDTH: combinational read data.
- `write_warp_id` in WW: target warp for writes and mask operations.
- `decoded_reg_write_enable` in 1: register write request.
- `decoded_rd_address` in RW: destination register index.
- `decoded_reg_input_mux` in `reg_input_mux_t`: write data source select.
- `decoded_immediate`, `alu_out`, `lsu_out`, `vector_to_scalar_data` in DATA_WIDTH: write data sources.
- `pc` in `instruction_memory_address_t`: program counter, used by the `PC_PLUS_1` source.
- `mask_push` in 1: save the current mask on the stack and install `push_mask`.
- `mask_pop` in 1: restore the mask from the top of the stack.
- `push_mask` in DATA_WIDTH: new mask value for push.
- `warp_execution_masks` out NUM_WARPS×DATA_WIDTH: flattened; warp w occupies bits `[w*DATA_WIDTH +: DATA_WIDTH]`.
- `mask_stack_depth` out DW: current stack depth of `debug_warp_id`.
- `stack_overflow`, `stack_underflow` out NUM_WARPS: per-warp sticky error flags.
- `debug_warp_id` in WW, `debug_reg_addr` in RW: debug read select.
- `debug_reg_data` out DATA_WIDTH: combinational debug read data.

## Operation
- **Special registers.** r0 always reads 0, and writes to it are dropped. `MASK_REG = NUM_REGS-1` holds the execution mask.
- **Reset values, every warp.** r1 = all ones; `MASK_REG` = all ones; all other registers = 0; stack depth = 0; both flags = 0. While `reset` is high, `rs1`/`rs2` = 0.
- **Update condition.** `upd = enable && warp_state==WARP_UPDATE`. Without `upd`, no state changes at all.
- **Register write.** Occurs when `upd && decoded_reg_write_enable && rd != 0`. The written value is selected by the mux:
  - `ALU_OUT` → `alu_out`
  - `LSU_OUT` → `lsu_out`
  - `IMMEDIATE` → `decoded_immediate`
  - `PC_PLUS_1` → `pc + 1`, zero-extended or truncated to DATA_WIDTH
  - `VECTOR_TO_SCALAR` → `vector_to_scalar_data`
  - any other mux value: no write.
- **Push (`upd`, push only).**
  - If depth < `MASK_STACK_DEPTH`: stack[depth] ← current mask; mask ← `push_mask`; depth +1.
  - If full: no change; set `stack_overflow[w]`.
- **Pop (`upd`, pop only).**
  - If depth > 0: mask ← stack[depth-1]; depth −1.
  - If empty: mask unchanged; set `stack_underflow[w]`.
- **Push and pop in the same cycle.** mask ← `push_mask`; depth and stack unchanged; no flag is set.
- **Priority on `MASK_REG`.** A mask operation overrides a same-cycle register write to `MASK_REG` of the same warp. Register writes to other rd still occur in that cycle.
- **Other warps.** Mask operations affect only `write_warp_id`.
- **Flags.** Cleared only by reset.

## Timing
- Reads (`rs1`, `rs2`, `debug_reg_data`, masks, depth) are combinational from current state.
- There is no write-to-read bypass: a write or mask operation in cycle N is visible on outputs from cycle N+1.
- Write latency is 1 cycle.
- A reset asserted mid-operation discards any same-cycle write or mask operation and restores all reset values at that edge.
- `read_warp_id == write_warp_id` in the same cycle is legal: the read returns the old value.

## Test plan
- **Reset.** Assert `reset` 1 cycle. Then warp 2, r1 = 0xFFFFFFFF; r5 = 0; mask = 0xFFFFFFFF; depth 0; flags 0.
- **Write sources and r0.** Write warp 1 r7 with `ALU_OUT` = 0x1234 → r7 reads 0x1234 next cycle; warp 0 r7 still reads 0. Write r0 with 0xDEAD → r0 still reads 0. Write with `PC_PLUS_1`, pc = 9 → reads 10. Repeat with `warp_state != WARP_UPDATE` → value unchanged.
- **Push/pop.** On warp 0: push 0x0F, then push 0x03 → mask 0x03, depth 2. Pop → mask 0x0F. Pop → mask 0xFFFFFFFF, depth 0. Warp 1 mask stays 0xFFFFFFFF throughout.
- **Overflow/underflow.** `MASK_STACK_DEPTH = 2`. Three pushes → depth 2, mask = second pushed value, `stack_overflow[0]` = 1. Three pops → mask 0xFFFFFFFF, `stack_underflow[0]` = 1; both flags persist.
- **Simultaneous push+pop.** At depth 1, push+pop with 0xAA → mask 0xAA, depth 1, no flags. Same cycle as a register write of 0x55 to `MASK_REG` plus a push of 0x11 → mask 0x11.
- **Reset mid-operation.** Reset in the same cycle as a push and a write to r4 → depth 0, mask all ones, r4 = 0.
